// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory port between icache and dcache, and steers
// returning load tags back to the cache that issued them.
module mem_arbiter #(
  parameter int MAX_STREAK = 4,
  parameter int NUM_TAGS   = 16,
  parameter int XLEN       = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      Icache2mem_command,
  input  logic [XLEN-1:0] Icache2mem_addr,
  input  logic [1:0]      Dcache2mem_command,
  input  logic [XLEN-1:0] Dcache2mem_addr,
  input  logic [63:0]     Dcache2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2Icache_response,
  output logic [3:0]      mem2Icache_tag,
  output logic [63:0]     mem2Icache_data,
  output logic [3:0]      mem2Dcache_response,
  output logic [3:0]      mem2Dcache_tag,
  output logic [63:0]     mem2Dcache_data,
  output logic            arb_error
);

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;
  localparam int         SW       = $clog2(MAX_STREAK + 1);

  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_TAGS-1:0] owner_q, owner_d;   // 1 = dcache, 0 = icache
  logic [SW-1:0]       streak_q, streak_d;
  logic                err_q, err_d;

  logic i_act, d_act, gnt_i, gnt_d, accepted, tag_hit, tag_orphan;

  always_comb begin
    i_act = (Icache2mem_command != CMD_NONE);
    d_act = (Dcache2mem_command != CMD_NONE);
    // dcache keeps priority unless it has starved a waiting icache
    gnt_d = !reset && d_act && ((streak_q < SW'(MAX_STREAK)) || !i_act);
    gnt_i = !reset && i_act && !gnt_d;
    accepted = (gnt_d || gnt_i) && (mem2proc_response != 4'd0);
    tag_hit    = !reset && (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
    tag_orphan = !reset && (mem2proc_tag != 4'd0) && !valid_q[mem2proc_tag];
  end

  always_comb begin
    proc2mem_command    = CMD_NONE;
    proc2mem_addr       = '0;
    proc2mem_data       = '0;
    mem2Icache_response = 4'd0;
    mem2Dcache_response = 4'd0;
    if (gnt_d) begin
      proc2mem_command    = Dcache2mem_command;
      proc2mem_addr       = Dcache2mem_addr;
      proc2mem_data       = Dcache2mem_data;
      mem2Dcache_response = mem2proc_response;
    end else if (gnt_i) begin
      proc2mem_command    = Icache2mem_command;
      proc2mem_addr       = Icache2mem_addr;
      mem2Icache_response = mem2proc_response;
    end
    mem2Icache_tag  = (tag_hit && !owner_q[mem2proc_tag]) ? mem2proc_tag : 4'd0;
    mem2Dcache_tag  = (tag_hit &&  owner_q[mem2proc_tag]) ? mem2proc_tag : 4'd0;
    mem2Icache_data = mem2proc_data;
    mem2Dcache_data = mem2proc_data;
    arb_error       = err_q;
  end

  always_comb begin
    valid_d  = valid_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    err_d    = err_q | tag_orphan;
    if (mem2proc_tag != 4'd0)
      valid_d[mem2proc_tag] = 1'b0;
    // applied after the clear so a same-cycle re-accept of the returning tag sticks
    if (accepted && (proc2mem_command == CMD_LOAD)) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = gnt_d;
    end
    if (!i_act)
      streak_d = '0;
    else if (accepted && gnt_d)
      streak_d = (streak_q == SW'(MAX_STREAK)) ? streak_q : streak_q + SW'(1);
    else if (accepted && gnt_i)
      streak_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= '0;
      owner_q  <= '0;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle reference model plus literal
// expectations for each scenario.
module tb_mem_arbiter;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] IA = 32'h100;
  localparam logic [XLEN-1:0] DA = 32'h200;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      Icache2mem_command, Dcache2mem_command;
  logic [XLEN-1:0] Icache2mem_addr, Dcache2mem_addr;
  logic [63:0]     Dcache2mem_data, mem2proc_data;
  logic [3:0]      mem2proc_response, mem2proc_tag;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data, mem2Icache_data, mem2Dcache_data;
  logic [3:0]      mem2Icache_response, mem2Icache_tag, mem2Dcache_response, mem2Dcache_tag;
  logic            arb_error;

  mem_arbiter #(.MAX_STREAK(4), .NUM_TAGS(16), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .Icache2mem_command(Icache2mem_command), .Icache2mem_addr(Icache2mem_addr),
    .Dcache2mem_command(Dcache2mem_command), .Dcache2mem_addr(Dcache2mem_addr),
    .Dcache2mem_data(Dcache2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2Icache_response(mem2Icache_response), .mem2Icache_tag(mem2Icache_tag),
    .mem2Icache_data(mem2Icache_data),
    .mem2Dcache_response(mem2Dcache_response), .mem2Dcache_tag(mem2Dcache_tag),
    .mem2Dcache_data(mem2Dcache_data),
    .arb_error(arb_error)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;
  bit done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: who owns each tag, how many dcache wins in a row, error flag.
  bit mvalid[16];
  bit mown_d[16];
  int mstreak = 0;
  bit merr = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      if (!done) begin
        int g;  // 0 none, 1 icache, 2 dcache
        bit acc, hit;
        logic [1:0] ecmd;
        logic [3:0] tg, rsp;
        tg  = mem2proc_tag;
        rsp = mem2proc_response;
        if (reset) g = 0;
        else if (Dcache2mem_command != 0 && (mstreak < 4 || Icache2mem_command == 0)) g = 2;
        else if (Icache2mem_command != 0) g = 1;
        else g = 0;
        ecmd = (g == 2) ? Dcache2mem_command : (g == 1) ? Icache2mem_command : 2'd0;
        hit = !reset && tg != 0 && mvalid[tg];
        chk("m_cmd",  proc2mem_command, ecmd);
        chk("m_addr", proc2mem_addr, (g == 2) ? Dcache2mem_addr : (g == 1) ? Icache2mem_addr : '0);
        chk("m_data", proc2mem_data, (g == 2) ? Dcache2mem_data : 64'd0);
        chk("m_iresp", mem2Icache_response, (g == 1) ? rsp : 4'd0);
        chk("m_dresp", mem2Dcache_response, (g == 2) ? rsp : 4'd0);
        chk("m_itag", mem2Icache_tag, (hit && !mown_d[tg]) ? tg : 4'd0);
        chk("m_dtag", mem2Dcache_tag, (hit &&  mown_d[tg]) ? tg : 4'd0);
        chk("m_idata", mem2Icache_data, mem2proc_data);
        chk("m_ddata", mem2Dcache_data, mem2proc_data);
        chk("m_err", arb_error, merr);
        // advance model to the state after the coming clock edge
        if (reset) begin
          foreach (mvalid[k]) begin mvalid[k] = 0; mown_d[k] = 0; end
          mstreak = 0;
          merr = 0;
        end else begin
          acc = (g != 0) && (rsp != 0);
          if (tg != 0 && !mvalid[tg]) merr = 1;
          if (tg != 0) mvalid[tg] = 0;
          if (acc && ecmd == 2'd1) begin mvalid[rsp] = 1; mown_d[rsp] = (g == 2); end
          if (Icache2mem_command == 0) mstreak = 0;
          else if (acc) mstreak = (g == 2) ? ((mstreak < 4) ? mstreak + 1 : 4) : 0;
        end
      end
    end
  end

  task automatic set(input logic [1:0] ic, input logic [1:0] dc, input logic [63:0] dd,
                     input logic [3:0] rsp, input logic [3:0] tg);
    Icache2mem_command = ic;
    Icache2mem_addr    = (ic != 0) ? IA : '0;
    Dcache2mem_command = dc;
    Dcache2mem_addr    = (dc != 0) ? ((dc == 2) ? 32'h10 : DA) : '0;
    Dcache2mem_data    = dd;
    mem2proc_response  = rsp;
    mem2proc_tag       = tg;
    mem2proc_data      = {32'hCAFE0000, 28'd0, tg};
    #1;
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set(0, 0, 0, 0, 0);
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  initial begin
    string pat;
    pat = "DDDDIDDDDI";
    reset = 1'b1;
    set(0, 0, 0, 0, 0);
    @(posedge clock);
    do_reset();

    // 1: icache-only load, tag returns five cycles later
    set(1, 0, 0, 3, 0);
    chk("t1_iresp", mem2Icache_response, 4'd3);
    chk("t1_dresp", mem2Dcache_response, 4'd0);
    chk("t1_addr", proc2mem_addr, 64'h100);
    nxt();
    for (int k = 0; k < 4; k++) begin set(0, 0, 0, 0, 0); nxt(); end
    set(0, 0, 0, 0, 3);
    chk("t1_itag", mem2Icache_tag, 4'd3);
    chk("t1_dtag", mem2Dcache_tag, 4'd0);
    nxt();
    set(0, 0, 0, 0, 0);
    chk("t1_err", arb_error, 1'b0);
    nxt();

    // 2: simultaneous loads, dcache first then icache
    set(1, 1, 0, 5, 0);
    chk("t2_dresp", mem2Dcache_response, 4'd5);
    chk("t2_iresp", mem2Icache_response, 4'd0);
    nxt();
    set(1, 0, 0, 6, 0);
    chk("t2_iresp2", mem2Icache_response, 4'd6);
    chk("t2_addr2", proc2mem_addr, 64'h100);
    nxt();

    // 5: tag 7 returns to dcache while being re-accepted for icache
    set(0, 1, 0, 7, 0);
    nxt();
    set(1, 0, 0, 7, 7);
    chk("t5_dtag_old", mem2Dcache_tag, 4'd7);
    chk("t5_itag_old", mem2Icache_tag, 4'd0);
    chk("t5_iresp", mem2Icache_response, 4'd7);
    nxt();
    set(0, 0, 0, 0, 7);
    chk("t5_itag_new", mem2Icache_tag, 4'd7);
    chk("t5_dtag_new", mem2Dcache_tag, 4'd0);
    nxt();
    set(0, 0, 0, 0, 0);
    chk("t5_err", arb_error, 1'b0);
    nxt();

    // 4: continuous contention, four dcache grants then one icache grant
    do_reset();
    for (int k = 0; k < 10; k++) begin
      set(1, 1, 0, 4'((k % 15) + 1), 0);
      chk($sformatf("t4_grant%0d", k), proc2mem_addr, (pat[k] == "D") ? 64'h200 : 64'h100);
      nxt();
    end

    // 3: store passes through without claiming a tag
    do_reset();
    set(0, 2, 64'hDEADBEEF, 2, 0);
    chk("t3_cmd", proc2mem_command, 2'd2);
    chk("t3_data", proc2mem_data, 64'hDEADBEEF);
    chk("t3_addr", proc2mem_addr, 64'h10);
    chk("t3_dresp", mem2Dcache_response, 4'd2);
    nxt();
    set(0, 0, 0, 0, 2);
    chk("t3_dtag", mem2Dcache_tag, 4'd0);
    nxt();
    set(0, 0, 0, 0, 0);
    chk("t3_err", arb_error, 1'b1);
    nxt();

    // 6: reset with tags outstanding, orphan return, rejected grants
    do_reset();
    chk("t6_err_clr", arb_error, 1'b0);
    set(0, 1, 0, 1, 0);
    nxt();
    set(0, 1, 0, 2, 0);
    nxt();
    reset = 1'b1;
    set(1, 1, 0, 3, 0);
    chk("t6_rst_cmd", proc2mem_command, 2'd0);
    chk("t6_rst_dresp", mem2Dcache_response, 4'd0);
    chk("t6_rst_iresp", mem2Icache_response, 4'd0);
    nxt();
    reset = 1'b0;
    set(0, 0, 0, 0, 1);
    chk("t6_orph_itag", mem2Icache_tag, 4'd0);
    chk("t6_orph_dtag", mem2Dcache_tag, 4'd0);
    nxt();
    set(0, 0, 0, 0, 0);
    chk("t6_err", arb_error, 1'b1);
    nxt();
    set(1, 1, 0, 3, 0); chk("t6_a1", proc2mem_addr, 64'h200); nxt();
    set(1, 1, 0, 4, 0); chk("t6_a2", proc2mem_addr, 64'h200); nxt();
    set(1, 1, 0, 0, 0); chk("t6_r1", proc2mem_addr, 64'h200); nxt();
    set(1, 1, 0, 0, 0); chk("t6_r2", proc2mem_addr, 64'h200); nxt();
    set(1, 1, 0, 5, 0); chk("t6_a3", proc2mem_addr, 64'h200); nxt();
    set(1, 1, 0, 6, 0); chk("t6_a4", proc2mem_addr, 64'h200); nxt();
    set(1, 1, 0, 8, 0); chk("t6_forced_i", proc2mem_addr, 64'h100); nxt();
    set(0, 0, 0, 0, 0);
    nxt();

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
